// File: rtl/arb2_rr_tenure.sv
// arb2_rr_tenure: two-requester round-robin arbiter with grant hold and a
// bounded tenure. The grant is a registered one-hot decode of the FSM state.
// A granted requester keeps the grant while it requests. While the other
// requester is also waiting, it keeps it for at most MAX_TENURE cycles.
// MAX_TENURE = 0 disables pre-emption.
// Optional build macro ARB2_STATS_EN adds the grant_cnt0_o and grant_cnt1_o
// acquisition counters.
//
// Handshake: request_i[i] is a level request sampled at every posedge. The
// grant is a level ownership indication that changes only at posedge. There
// is no valid/ready pairing: a requester owns the resource for every cycle in
// which its grant_o bit is high.
module arb2_rr_tenure #(
   parameter int  MAX_TENURE = 8,
   localparam int CNT_W      = (MAX_TENURE == 0) ? 1 :
                               (($clog2(MAX_TENURE + 1) < 1) ? 1 : $clog2(MAX_TENURE + 1))
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [1:0]       request_i,
   output logic [1:0]       grant_o,
   output logic             last_winner_o,
   output logic [CNT_W-1:0] tenure_o,
   output logic [1:0]       state_o
`ifdef ARB2_STATS_EN
   ,
   output logic [15:0]      grant_cnt0_o,
   output logic [15:0]      grant_cnt1_o
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_t;

   // The tenure counter stops at MAX_TENURE-1. With pre-emption disabled it
   // stops at all-ones instead.
   localparam int               SAT_INT = (MAX_TENURE == 0) ? ((2 ** CNT_W) - 1) : (MAX_TENURE - 1);
   localparam logic [CNT_W-1:0] TEN_SAT = SAT_INT[CNT_W-1:0];
   localparam logic [CNT_W-1:0] TEN_ONE = 1;
   localparam logic [CNT_W-1:0] TEN_ZERO = 0;
   localparam bit               PREEMPT = (MAX_TENURE > 0);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] tenure_q, tenure_d;
   logic             last_winner_q, last_winner_d;

   logic             own_idx;
   logic             own_req;
   logic             oth_req;

   // The requests of the current owner and of the other requester.
   assign own_idx = (state_q == OWN1);
   assign own_req = request_i[own_idx];
   assign oth_req = request_i[~own_idx];

   // State, tenure and last winner registers. Reset makes requester 0 win the first tie.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= IDLE;
         tenure_q      <= TEN_ZERO;
         last_winner_q <= 1'b1;
      end else begin
         state_q       <= state_d;
         tenure_q      <= tenure_d;
         last_winner_q <= last_winner_d;
      end
   end

   // Next-state logic: arbitration from IDLE, release or handoff, and pre-emption on a full tenure.
   always_comb begin
      state_d       = state_q;
      tenure_d      = tenure_q;
      last_winner_d = last_winner_q;
      case (state_q)
         IDLE: begin
            tenure_d = TEN_ZERO;
            case (request_i)
               2'b01: begin
                  state_d       = OWN0;
                  last_winner_d = 1'b0;
               end
               2'b10: begin
                  state_d       = OWN1;
                  last_winner_d = 1'b1;
               end
               2'b11: begin
                  state_d       = last_winner_q ? OWN0 : OWN1;
                  last_winner_d = ~last_winner_q;
               end
               default: state_d = IDLE;
            endcase
         end
         OWN0, OWN1: begin
            if (!own_req) begin
               // Release: hand straight over if the other side is waiting.
               tenure_d = TEN_ZERO;
               if (oth_req) begin
                  state_d       = own_idx ? OWN0 : OWN1;
                  last_winner_d = ~own_idx;
               end else begin
                  state_d = IDLE;
               end
            end else if (oth_req && PREEMPT && (tenure_q == TEN_SAT)) begin
               // The tenure is used up and the other requester is waiting.
               state_d       = own_idx ? OWN0 : OWN1;
               last_winner_d = ~own_idx;
               tenure_d      = TEN_ZERO;
            end else if (tenure_q != TEN_SAT) begin
               tenure_d = tenure_q + TEN_ONE;
            end
         end
         default: begin
            state_d  = IDLE;
            tenure_d = TEN_ZERO;
         end
      endcase
   end

   assign grant_o       = {state_q == OWN1, state_q == OWN0};
   assign last_winner_o = last_winner_q;
   assign tenure_o      = tenure_q;
   assign state_o       = state_q;

`ifdef ARB2_STATS_EN
   logic [15:0] cnt0_q, cnt1_q;
   logic        enter0, enter1;

   assign enter0 = (state_d == OWN0) && (state_q != OWN0);
   assign enter1 = (state_d == OWN1) && (state_q != OWN1);

   // Saturating counts of grant acquisitions. Held cycles are not counted.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt0_q <= 16'd0;
         cnt1_q <= 16'd0;
      end else begin
         if (enter0 && (cnt0_q != 16'hFFFF)) cnt0_q <= cnt0_q + 16'd1;
         if (enter1 && (cnt1_q != 16'hFFFF)) cnt1_q <= cnt1_q + 16'd1;
      end
   end

   assign grant_cnt0_o = cnt0_q;
   assign grant_cnt1_o = cnt1_q;
`endif

endmodule

// File: tb/tb_arb2_rr_tenure.sv
// Bench for arb2_rr_tenure: directed vector table, a hand-written pre-emption
// sequence, and random requests checked against an ownership model.
module tb_arb2_rr_tenure;

   localparam int MAXT  = 8;
   localparam int CNTW  = $clog2(MAXT + 1);
   localparam int SAT   = MAXT - 1;

   logic            clk;
   logic            rst;
   logic [1:0]      request;
   logic [1:0]      grant;
   logic            last_winner;
   logic [CNTW-1:0] tenure;
   logic [1:0]      state;
`ifdef ARB2_STATS_EN
   logic [15:0]     grant_cnt0;
   logic [15:0]     grant_cnt1;
`endif

   int checks = 0;
   int errors = 0;

   // Clock and reset block: 10 ns period. Inputs change 1 ns after each posedge.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   arb2_rr_tenure #(.MAX_TENURE(MAXT)) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .request_i     (request),
      .grant_o       (grant),
      .last_winner_o (last_winner),
      .tenure_o      (tenure),
      .state_o       (state)
`ifdef ARB2_STATS_EN
      ,
      .grant_cnt0_o  (grant_cnt0),
      .grant_cnt1_o  (grant_cnt1)
`endif
   );

   typedef struct {
      logic       rst;
      logic [1:0] req;
      logic [1:0] g;
      logic       lw;
      int         ten;
   } vec_t;

   vec_t tbl[$];

   // Ownership model: who owns the resource and for how many cycles.
   int m_owner;
   int m_held;
   int m_lw;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Driver: apply inputs, let one posedge sample them, then settle past the edge.
   task automatic step(input logic r, input logic [1:0] q);
      rst     = r;
      request = q;
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic r, input logic [1:0] q, input logic [1:0] g,
                      input logic lw, input int ten);
      vec_t v;
      v.rst = r; v.req = q; v.g = g; v.lw = lw; v.ten = ten;
      tbl.push_back(v);
   endtask

   task automatic model_step(input logic r, input logic [1:0] q);
      int o;
      int oth;
      if (r) begin
         m_owner = -1; m_held = 0; m_lw = 1;
      end else if (m_owner < 0) begin
         if (q != 2'b00) begin
            m_owner = (q == 2'b11) ? (1 - m_lw) : (q[1] ? 1 : 0);
            m_held  = 1;
            m_lw    = m_owner;
         end
      end else begin
         o   = m_owner;
         oth = 1 - o;
         if (!q[o]) begin
            if (q[oth]) begin
               m_owner = oth; m_held = 1; m_lw = oth;
            end else begin
               m_owner = -1; m_held = 0;
            end
         end else if (q[oth] && (m_held >= MAXT)) begin
            m_owner = oth; m_held = 1; m_lw = oth;
         end else begin
            m_held++;
         end
      end
   endtask

   function automatic int exp_grant();
      return (m_owner < 0) ? 0 : (1 << m_owner);
   endfunction

   function automatic int exp_tenure();
      if (m_owner < 0) return 0;
      return ((m_held - 1) > SAT) ? SAT : (m_held - 1);
   endfunction

   initial begin
      rst     = 1'b1;
      request = 2'b00;

      // Reset for 2 cycles, then a single requester for 5 cycles.
      add(1, 2'b00, 2'b00, 1, 0);
      add(1, 2'b00, 2'b00, 1, 0);
      for (int i = 0; i < 5; i++) add(0, 2'b01, 2'b01, 0, i);
      add(0, 2'b00, 2'b00, 0, 0);
      // First tie after reset goes to requester 0, then a gap-free handoff.
      add(1, 2'b00, 2'b00, 1, 0);
      add(0, 2'b11, 2'b01, 0, 0);
      add(0, 2'b10, 2'b10, 1, 0);
      add(0, 2'b00, 2'b00, 1, 0);
      // Uncontended hold saturates the tenure, then pre-emption at the next edge.
      for (int i = 0; i < 12; i++) add(0, 2'b10, 2'b10, 1, (i > SAT) ? SAT : i);
      add(0, 2'b11, 2'b01, 0, 0);
      add(0, 2'b11, 2'b01, 0, 1);
      // Handoff to 1, then reset mid-grant, then the tie goes to requester 0.
      add(0, 2'b10, 2'b10, 1, 0);
      add(1, 2'b11, 2'b00, 1, 0);
      add(0, 2'b11, 2'b01, 0, 0);
      add(0, 2'b00, 2'b00, 0, 0);

      foreach (tbl[k]) begin
         step(tbl[k].rst, tbl[k].req);
         check($sformatf("vec%0d_grant", k), int'(grant), int'(tbl[k].g));
         check($sformatf("vec%0d_last_winner", k), int'(last_winner), int'(tbl[k].lw));
         check($sformatf("vec%0d_tenure", k), int'(tenure), tbl[k].ten);
      end

      // Contention for 20 cycles: 01 x8, 10 x8, 01 x4, tenure 0..7 per owner.
      step(1, 2'b00);
      for (int i = 0; i < 20; i++) begin
         step(0, 2'b11);
         check($sformatf("preempt%0d_grant", i), int'(grant), ((i / 8) % 2 == 0) ? 1 : 2);
         check($sformatf("preempt%0d_tenure", i), int'(tenure), i % 8);
      end
`ifdef ARB2_STATS_EN
      check("stats_cnt0", int'(grant_cnt0), 2);
      check("stats_cnt1", int'(grant_cnt1), 1);
      step(1, 2'b11);
      check("stats_cnt0_rst", int'(grant_cnt0), 0);
      check("stats_cnt1_rst", int'(grant_cnt1), 0);
`endif

      // Random phase against the ownership model.
      step(1, 2'b00);
      model_step(1, 2'b00);
      begin
         logic [1:0] q;
         logic       r;
         q = 2'b00;
         for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) q = 2'($urandom_range(0, 3));
            r = ($urandom_range(0, 79) == 0);
            step(r, q);
            model_step(r, q);
            check("rand_grant", int'(grant), exp_grant());
            check("rand_last_winner", int'(last_winner), m_lw);
            check("rand_tenure", int'(tenure), exp_tenure());
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/arb2_rr_tenure.md
Name: arb2_rr_tenure

Overview:
- Two-requester round-robin arbiter with grant hold and a bounded tenure.
- It is the DUT-side block behind the arbiter interface's DUT modport. It consumes `request[1:0]` driven by the testbench clocking block and produces a registered one-hot `grant[1:0]`.
- A granted requester keeps the grant while it holds its request, up to `MAX_TENURE` cycles when the other requester is contending. Ties are broken by round-robin on the last winner.

Parameters:
- `MAX_TENURE`, default 8: maximum consecutive grant cycles while the other requester waits. 0 means unlimited (no pre-emption).
- `CNT_W` (localparam), default `$clog2(MAX_TENURE+1)` with a minimum of 1: width of the tenure counter.

Ports:
- `clk` input 1: single clock; everything is on the posedge.
- `rst` input 1: synchronous, active-high reset.
- `request` input 2: `request[i]` high means requester i wants the resource. Sampled on the posedge.
- `grant` output 2: registered one-hot or zero. `grant[i]` high means requester i owns the resource.
- `last_winner` output 1: index of the most recently granted requester, used for the round-robin tie-break.
- `tenure` output CNT_W: cycles the current owner has held the grant, minus 1. It is 0 when idle.

Behaviour:
- Reset:
  - On any posedge with `rst`=1: `grant`=2'b00, state=IDLE, `tenure`=0, `last_winner`=1 (requester 0 wins the first tie).
  - Reset applies mid-grant. `grant` drops to 0 at that edge with no handoff.
- States: IDLE, OWN0, OWN1. `grant` is a pure decode of the state: IDLE→00, OWN0→01, OWN1→10.
- Latency: a request first sampled high at edge N produces grant at edge N. Grant is therefore visible to the testbench's clocking block at edge N+1. There is no combinational path from `request` to `grant`.
- IDLE:
  - request=01 → OWN0.
  - request=10 → OWN1.
  - request=11 → OWN(~`last_winner`).
  - request=00 → stay in IDLE.
  - On entering OWNi: `tenure`=0, `last_winner`=i.
- OWNi, `request[i]`=0 (release):
  - If `request[~i]`=1 → OWN(~i) at the same edge (no idle bubble). `tenure`=0, `last_winner`=~i.
  - Else → IDLE, `tenure`=0.
- OWNi, `request[i]`=1, `request[~i]`=0: stay in OWNi. `tenure` increments and saturates at `MAX_TENURE`-1; there is no wrap.
- OWNi, both requesting, `MAX_TENURE`>0:
  - If `tenure`==`MAX_TENURE`-1 → pre-empt to OWN(~i). `tenure`=0, `last_winner`=~i.
  - Else `tenure`++.
  - Result: requester i holds grant for exactly `MAX_TENURE` consecutive cycles under contention.
- OWNi, both requesting, `MAX_TENURE`==0: hold indefinitely. `tenure` saturates at its all-ones value.
- Saturation carry-over: a `tenure` that saturated while uncontended and then sees the other requester arrive pre-empts at the next edge.
- Invariants:
  - `grant` is never 2'b11.
  - `grant` changes only at posedge.
  - A handoff never inserts a cycle with `grant`=00 while any request is pending.
  - The pre-empted requester must re-arbitrate. If it still requests, it wins again after the other's tenure ends or is released.

Optional Feature:
- `ARB2_STATS_EN` defined: adds two output ports.
  - `grant_cnt0` and `grant_cnt1`, 16 bits each.
  - Each counts grant acquisitions (entries into OWNi, including handoffs and pre-emptions). It does not count held cycles.
  - Counters saturate at 16'hFFFF and clear on `rst`.
- `ARB2_STATS_EN` undefined: the ports and logic are absent. Core behaviour is identical.

Test Plan:
- Reset then single request: `rst`=1 for 2 cycles, then request=01 held 5 cycles then 00.
  - `grant`=01 from the first sampling edge for 5 cycles, then 00.
  - `last_winner`=0.
- First tie after reset: request=11 in the first cycle after reset → `grant`=01.
  - Release 0 (request=10) → `grant`=10 at the same edge, no 00 gap.
  - `last_winner`=1.
- Tenure pre-emption, `MAX_TENURE`=8: request=11 held 20 cycles → `grant` sequence 01×8, 10×8, 01×4.
  - `tenure` counts 0..7 in each ownership.
- Uncontended hold: request=10 for 12 cycles → `grant`=10 throughout, `tenure` saturates at 7.
  - Then request=11 → `grant`=01 on the next edge.
- Reset mid-grant: `grant`=10, request=11, assert `rst` for 1 cycle → `grant`=00 and `last_winner`=1.
  - With request still 11 after reset → `grant`=01.
- With `ARB2_STATS_EN`: run the pre-emption scenario → `grant_cnt0`=2, `grant_cnt1`=1. Then `rst` → both 0.
